alu_decode_stage: RTL

Decode-stage pipeline register that turns a fetched LoongArch32 instruction into the `alu_op`/`alu_src1`/`alu_src2` control bundle consumed by the execute-stage ALU.
- Sits between fetch and execute.
- Reads the register file combinationally at acceptance and holds one instruction under a valid/allowin handshake.
- Covers all ALU-class instructions; everything else is flagged instruction-not-exist.

---
 rtl/alu_decode_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// Decode-stage pipeline register: turns a LoongArch32 ALU-class instruction into
// the one-hot alu_op and operand bundle for execute, under a valid/allowin handshake.
module alu_decode_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_to_ds_valid,
  input  logic [31:0] fs_inst,
  input  logic [31:0] fs_pc,
  output logic        ds_allowin,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        flush,
  input  logic        es_allowin,
  output logic        ds_to_es_valid,
  output logic [11:0] es_alu_op,
  output logic [31:0] es_alu_src1,
  output logic [31:0] es_alu_src2,
  output logic [4:0]  es_dest,
  output logic        es_rf_we,
  output logic [31:0] es_pc,
  output logic        es_ine
);

  logic        ds_valid;
  logic        accept;

  logic [5:0]  op31_26;
  logic [3:0]  op25_22;
  logic [1:0]  op21_20;
  logic [4:0]  op19_15;
  logic [4:0]  rd;
  logic [4:0]  i5;
  logic [11:0] i12;
  logic [19:0] i20;

  logic        is_3r;
  logic        is_shift_imm;
  logic        is_2ri12;
  logic        is_lu12i;

  logic [11:0] dec_op;
  logic [31:0] dec_src1;
  logic [31:0] dec_src2;
  logic        dec_legal;

  assign op31_26 = fs_inst[31:26];
  assign op25_22 = fs_inst[25:22];
  assign op21_20 = fs_inst[21:20];
  assign op19_15 = fs_inst[19:15];
  assign rd      = fs_inst[4:0];
  assign i5      = fs_inst[14:10];
  assign i12     = fs_inst[21:10];
  assign i20     = fs_inst[24:5];

  assign rf_raddr1 = fs_inst[9:5];
  assign rf_raddr2 = fs_inst[14:10];

  assign is_3r        = (op31_26 == 6'h00) && (op25_22 == 4'h0) && (op21_20 == 2'b01);
  assign is_shift_imm = (op31_26 == 6'h00) && (op25_22 == 4'h1) && (op21_20 == 2'b00);
  assign is_2ri12     = (op31_26 == 6'h00);
  assign is_lu12i     = (fs_inst[31:25] == 7'b0001010);

  assign ds_to_es_valid = ds_valid;
  assign ds_allowin     = !ds_valid || es_allowin;
  assign accept         = fs_to_ds_valid && ds_allowin && !flush;

  // Group flags overlap on op31_26 == 0, so the more specific groups are tested first.
  always_comb begin
    dec_op    = '0;
    dec_src1  = '0;
    dec_src2  = '0;
    dec_legal = 1'b0;
    if (is_3r) begin
      dec_legal = 1'b1;
      dec_src1  = rf_rdata1;
      dec_src2  = rf_rdata2;
      case (op19_15)
        5'h00: dec_op[0] = 1'b1;
        5'h02: dec_op[1] = 1'b1;
        5'h04: dec_op[2] = 1'b1;
        5'h05: dec_op[3] = 1'b1;
        5'h08: dec_op[5] = 1'b1;
        5'h09: dec_op[4] = 1'b1;
        5'h0A: dec_op[6] = 1'b1;
        5'h0B: dec_op[7] = 1'b1;
        5'h0E: begin
          dec_op[8] = 1'b1;
          dec_src1  = {27'b0, rf_rdata2[4:0]};
          dec_src2  = rf_rdata1;
        end
        5'h0F: begin
          dec_op[9] = 1'b1;
          dec_src1  = {27'b0, rf_rdata2[4:0]};
          dec_src2  = rf_rdata1;
        end
        5'h10: begin
          dec_op[10] = 1'b1;
          dec_src1   = {27'b0, rf_rdata2[4:0]};
          dec_src2   = rf_rdata1;
        end
        default: dec_legal = 1'b0;
      endcase
    end else if (is_shift_imm) begin
      dec_legal = 1'b1;
      dec_src1  = {27'b0, i5};
      dec_src2  = rf_rdata1;
      case (op19_15)
        5'h01:   dec_op[8]  = 1'b1;
        5'h09:   dec_op[9]  = 1'b1;
        5'h11:   dec_op[10] = 1'b1;
        default: dec_legal  = 1'b0;
      endcase
    end else if (is_2ri12) begin
      dec_legal = 1'b1;
      dec_src1  = rf_rdata1;
      case (op25_22)
        4'hA: begin dec_op[0] = 1'b1; dec_src2 = {{20{i12[11]}}, i12}; end
        4'h8: begin dec_op[2] = 1'b1; dec_src2 = {{20{i12[11]}}, i12}; end
        4'h9: begin dec_op[3] = 1'b1; dec_src2 = {{20{i12[11]}}, i12}; end
        4'hD: begin dec_op[4] = 1'b1; dec_src2 = {20'b0, i12}; end
        4'hE: begin dec_op[6] = 1'b1; dec_src2 = {20'b0, i12}; end
        4'hF: begin dec_op[7] = 1'b1; dec_src2 = {20'b0, i12}; end
        default: dec_legal = 1'b0;
      endcase
    end else if (is_lu12i) begin
      dec_legal  = 1'b1;
      dec_op[11] = 1'b1;
      dec_src2   = {i20, 12'b0};
    end
    if (!dec_legal) begin
      dec_op   = '0;
      dec_src1 = '0;
      dec_src2 = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid    <= 1'b0;
      es_alu_op   <= '0;
      es_alu_src1 <= '0;
      es_alu_src2 <= '0;
      es_dest     <= '0;
      es_rf_we    <= 1'b0;
      es_pc       <= '0;
      es_ine      <= 1'b0;
    end else begin
      if (flush) begin
        ds_valid <= 1'b0;
      end else if (accept) begin
        ds_valid <= 1'b1;
      end else if (es_allowin) begin
        ds_valid <= 1'b0;
      end
      if (accept) begin
        es_alu_op   <= dec_op;
        es_alu_src1 <= dec_src1;
        es_alu_src2 <= dec_src2;
        es_dest     <= dec_legal ? rd : 5'd0;
        es_rf_we    <= dec_legal && (rd != 5'd0);
        es_pc       <= fs_pc;
        es_ine      <= !dec_legal;
      end
    end
  end

endmodule
